alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU control unit: decodes op/funct into the 4-bit ALU control code, executes the operation on WIDTH-bit operands and registers the result.
- Adds a valid/ready handshake on input and output, an extended op class (op=11) with signed set-less-than and multi-cycle shifts, an illegal-encoding flag and a zero flag.
- Sits in the execute stage between the decode/register-read stage and writeback.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4, power of 2).
- SHAMT_W, $clog2(WIDTH), width of the shift amount taken from b[SHAMT_W-1:0]. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  op/funct/a/b valid.
- in_ready  out  1  unit can accept a new operation this cycle.
- op  in  2  ALU op class: 00 load/store, 01 beq, 10 R-type, 11 extended.
- funct  in  3  function field.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B, or shift amount in its low bits.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- control  out  4  registered ALU control code of the completed operation.
- zero  out  1  result == 0.
- illegal  out  1  completed operation had an illegal encoding.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, result=0, control=0000, zero=0, illegal=0, internal acc/count=0. After release, in_ready=1.
- Decode table, op → control:
  - 00 → 0010 ADD (funct ignored).
  - 01 → 0110 SUB (funct ignored).
  - 10, by funct: 000 ADD 0010; 100 SUB 0110; 011 AND 0000; 010 OR 0001; 110 NAND 1101; 111 NOR 1100; 001/101 illegal.
  - 11, by funct: 000 SLT 0111 (signed a<b → 1, else 0); 001 SLL 1000; 010 SRL 1001 (logical); all others illegal.
- Illegal encodings: control=1111, result=0, illegal=1. Handled with 1-cycle latency.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output. SLT result is zero-extended 0/1.
- Handshake:
  - Accept when in_valid && in_ready on a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This gives back-to-back single-cycle throughput when the consumer is ready.
  - Output transfer occurs when out_valid && out_ready. result/control/zero/illegal are stable while out_valid=1 and out_ready=0.
  - out_valid drops on the transfer edge unless a new result is loaded on the same edge.
- State machine: IDLE, SHIFT.
  - IDLE, accept of a single-cycle op (including a shift with amount 0, which gives result=a): load outputs at that edge; out_valid=1 next cycle (latency 1). Stay in IDLE.
  - IDLE, accept of a shift with amount n≥1: acc←a, cnt←n, go to SHIFT; out_valid is cleared if the old result transfers on that edge.
  - SHIFT: each cycle acc shifts 1 bit (SLL left, SRL right, zero fill) and cnt decrements. On the edge where cnt==1: result←final acc, control, zero, illegal=0, out_valid←1, go to IDLE. Total latency n cycles from accept.
  - in_ready=0 throughout SHIFT. Inputs are ignored in SHIFT, even if in_valid=1.
- The shift amount uses only b[SHAMT_W-1:0]; upper bits of b are ignored.
- Reset mid-shift: immediately abandon; return to the reset values above. No result is produced.
- zero is computed from the value loaded into result.

Test Plan:
- WIDTH=8, op=00, a=0x05, b=0x03, out_ready=1 → one cycle after accept: out_valid=1, result=0x08, control=0010, zero=0, illegal=0.
- op=10, funct=110, a=0xF0, b=0x3C → result=0xCF, control=1101. Repeat with funct=111 → result=0x03, control=1100. Then funct=101 → illegal=1, control=1111, result=0x00.
- op=01, a=0x07, b=0x07 → result=0x00, zero=1, control=0110. Then op=11, funct=000, a=0xFF, b=0x01 → result=0x01 (signed −1<1), control=0111.
- op=11, funct=001, a=0x03, b=0x05 → in_ready=0 for cycles 1–4 after accept; out_valid=1 exactly 5 cycles after accept; result=0x60, control=1000. Repeat with b=0x00 → latency 1, result=0x03.
- Backpressure: out_ready=0 after an ADD completes → result held, in_ready=0 for ≥3 cycles. Raise out_ready together with a queued in_valid → old result transfers and new op is accepted on the same edge; new result is valid the next cycle.
- Assert rst_n=0 during SHIFT (op=11, funct=010, a=0x80, b=0x07, 3 cycles in) → out_valid=0 and result=0x00 immediately. After release in_ready=1, and no stale result ever appears.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decodes op/funct, executes on WIDTH-bit operands with valid/ready handshake
// and registered result; shifts by n>=1 iterate one bit per cycle in SHIFT.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [2:0]         funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         control,
  output logic               zero,
  output logic               illegal
);
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110,
                         C_SLT = 4'b0111, C_SLL = 4'b1000, C_SRL = 4'b1001, C_NOR = 4'b1100,
                         C_NAND = 4'b1101, C_ILL = 4'b1111;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_d;
  logic [3:0]         ctl;
  logic [WIDTH-1:0]   res, acc, acc_sh;
  logic [SHAMT_W-1:0] shamt, cnt;
  logic               left, accept, long_shift;
  assign shamt      = b[SHAMT_W-1:0];
  assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign long_shift = (ctl == C_SLL || ctl == C_SRL) && shamt != '0;
  assign acc_sh     = left ? acc << 1 : acc >> 1;
  always_comb begin
    ctl = C_ILL;
    case (op)
      2'b00: ctl = C_ADD;
      2'b01: ctl = C_SUB;
      2'b10:
        case (funct)
          3'b000:  ctl = C_ADD;
          3'b100:  ctl = C_SUB;
          3'b011:  ctl = C_AND;
          3'b010:  ctl = C_OR;
          3'b110:  ctl = C_NAND;
          3'b111:  ctl = C_NOR;
          default: ctl = C_ILL;
        endcase
      default:
        case (funct)
          3'b000:  ctl = C_SLT;
          3'b001:  ctl = C_SLL;
          3'b010:  ctl = C_SRL;
          default: ctl = C_ILL;
        endcase
    endcase
    case (ctl)
      C_ADD:   res = a + b;
      C_SUB:   res = a - b;
      C_AND:   res = a & b;
      C_OR:    res = a | b;
      C_NAND:  res = ~(a & b);
      C_NOR:   res = ~(a | b);
      C_SLT:   res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      C_SLL:   res = a << shamt;
      C_SRL:   res = a >> shamt;
      default: res = '0;
    endcase
  end
  always_comb begin
    state_d = state;
    if (state == IDLE && accept && long_shift) state_d = SHIFT;
    if (state == SHIFT && cnt == SHAMT_W'(1)) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      control   <= 4'b0000;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      left      <= 1'b0;
    end else begin
      state <= state_d;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == IDLE && accept) begin
        if (long_shift) begin
          acc  <= a;
          cnt  <= shamt;
          left <= ctl == C_SLL;
        end else begin
          result    <= res;
          control   <= ctl;
          zero      <= res == '0;
          illegal   <= ctl == C_ILL;
          out_valid <= 1'b1;
        end
      end else if (state == SHIFT) begin
        acc <= acc_sh;
        cnt <= cnt - 1'b1;
        if (cnt == SHAMT_W'(1)) begin
          result    <= acc_sh;
          control   <= left ? C_SLL : C_SRL;
          zero      <= acc_sh == '0;
          illegal   <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule
